// File: rtl/pulse_interval_meter.sv
// Coarse-count leg of the TDC test path: counts clk cycles from a start rise
// to the following stop rise and offers the result on a valid/ready port.
module pulse_interval_meter #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned TIMEOUT     = 1000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             result_ready,
  output logic             busy,
  output logic             result_valid,
  output logic [CNT_W-1:0] result_interval,
  output logic             result_timeout,
  output logic [7:0]       missed_starts
);

  localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    HOLD
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       interval_q, interval_d;
  logic                   timeout_q, timeout_d;
  logic [7:0]             missed_q, missed_d;
  logic [SYNC_STAGES-1:0] start_sync_q;
  logic [SYNC_STAGES-1:0] stop_sync_q;
  logic                   start_hist_q;
  logic                   stop_hist_q;
  logic                   start_rise;
  logic                   stop_rise;

  // Both inputs share an identical path so synchronizer latency cancels out.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_sync_q <= '0;
      stop_sync_q  <= '0;
      start_hist_q <= 1'b0;
      stop_hist_q  <= 1'b0;
    end else begin
      start_sync_q <= {start_sync_q[SYNC_STAGES-2:0], start};
      stop_sync_q  <= {stop_sync_q[SYNC_STAGES-2:0], stop};
      start_hist_q <= start_sync_q[SYNC_STAGES-1];
      stop_hist_q  <= stop_sync_q[SYNC_STAGES-1];
    end
  end

  assign start_rise = start_sync_q[SYNC_STAGES-1] & ~start_hist_q;
  assign stop_rise  = stop_sync_q[SYNC_STAGES-1] & ~stop_hist_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      interval_q <= '0;
      timeout_q  <= 1'b0;
      missed_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      interval_q <= interval_d;
      timeout_q  <= timeout_d;
      missed_q   <= missed_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    interval_d = interval_q;
    timeout_d  = timeout_q;
    missed_d   = missed_q;

    // Any start edge that cannot begin a measurement is recorded, saturating.
    if (start_rise && (state_q != IDLE) && (missed_q != 8'hFF)) begin
      missed_d = missed_q + 8'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (start_rise) begin
          timeout_d = 1'b0;
          if (stop_rise) begin
            interval_d = '0;
            state_d    = HOLD;
          end else begin
            cnt_d   = CNT_W'(1);
            state_d = COUNT;
          end
        end
      end
      COUNT: begin
        if (stop_rise) begin
          interval_d = cnt_q;
          timeout_d  = 1'b0;
          state_d    = HOLD;
        end else if (cnt_q == TimeoutVal) begin
          interval_d = TimeoutVal;
          timeout_d  = 1'b1;
          state_d    = HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (result_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy            = (state_q == COUNT) || (state_q == HOLD);
  assign result_valid    = (state_q == HOLD);
  assign result_interval = interval_q;
  assign result_timeout  = timeout_q;
  assign missed_starts   = missed_q;

endmodule

// File: tb/tb_pulse_interval_meter.sv
// Randomized bench for pulse_interval_meter: drives start/stop pins with
// known spacing and compares results against interval rules computed here.
module tb_pulse_interval_meter;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 20;
  localparam int SYNC    = 2;

  logic             clk;
  logic             rst;
  logic             start;
  logic             stop;
  logic             resultReady;
  logic             busy;
  logic             resultValid;
  logic [CNT_W-1:0] resultInterval;
  logic             resultTimeout;
  logic [7:0]       missedStarts;

  int testsRun    = 0;
  int testsFailed = 0;
  int expMissed   = 0;

  pulse_interval_meter #(
    .CNT_W      (CNT_W),
    .TIMEOUT    (TIMEOUT),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .stop           (stop),
    .result_ready   (resultReady),
    .busy           (busy),
    .result_valid   (resultValid),
    .result_interval(resultInterval),
    .result_timeout (resultTimeout),
    .missed_starts  (missedStarts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic void bumpMissed();
    if (expMissed < 255) expMissed++;
  endfunction

  // One measurement: stop pin follows start pin by k cycles (k > TIMEOUT means no stop).
  task automatic applyStimulus(input int k, input int readyDelay, input bit extraStartReq,
                               input int holdStarts);
    int  expInt;
    bit  expTo;
    int  busyCycles;
    int  i;
    int  limit;
    bit  seen;
    bit  useReady;
    bit  extraStart;
    logic [31:0] holdOk;
    expTo      = (k > TIMEOUT);
    expInt     = expTo ? TIMEOUT : k;
    useReady   = (readyDelay == 0) && (holdStarts == 0);
    extraStart = extraStartReq && (k >= 7);
    busyCycles = 0;
    seen       = 1'b0;
    i          = 0;
    limit      = TIMEOUT + 20;
    resultReady = useReady;

    @(negedge clk);
    start = 1'b1;
    if (k == 0) stop = 1'b1;
    while (!seen && i < limit) begin
      @(negedge clk);
      i++;
      if (i == 2) begin
        start = 1'b0;
        if (k == 0) stop = 1'b0;
      end
      if (k >= 1 && k <= TIMEOUT && i == k)     stop = 1'b1;
      if (k >= 1 && k <= TIMEOUT && i == k + 2) stop = 1'b0;
      if (extraStart && i == 4) start = 1'b1;
      if (extraStart && i == 6) start = 1'b0;
      if (busy) busyCycles++;
      if (resultValid) seen = 1'b1;
    end
    start = 1'b0;
    stop  = 1'b0;
    checkOutput("valid_seen", 32'(seen), 1);
    checkOutput("interval", 32'(resultInterval), 32'(expInt));
    checkOutput("timeout_flag", 32'(resultTimeout), 32'(expTo));
    if (useReady) checkOutput("busy_cycles", 32'(busyCycles), 32'(expInt + 1));
    if (extraStart) bumpMissed();

    for (int p = 0; p < holdStarts; p++) begin
      start = 1'b1;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (c == 1) start = 1'b0;
        holdOk = 32'(resultValid && resultInterval == CNT_W'(expInt) && resultTimeout == expTo);
        checkOutput("hold_stable", holdOk, 1);
      end
      bumpMissed();
    end
    repeat (readyDelay + ((holdStarts > 0) ? 4 : 0)) begin
      @(negedge clk);
      holdOk = 32'(resultValid && resultInterval == CNT_W'(expInt) && resultTimeout == expTo);
      checkOutput("hold_stable", holdOk, 1);
    end

    resultReady = 1'b1;
    @(negedge clk);
    checkOutput("valid_drop", 32'(resultValid), 0);
    checkOutput("busy_after", 32'(busy), 0);
    checkOutput("interval_kept", 32'(resultInterval), 32'(expInt));
    repeat (6) @(negedge clk);
    checkOutput("missed_starts", 32'(missedStarts), 32'(expMissed));
  endtask

  task automatic pulseStopIdle();
    bit sawValid;
    sawValid = 1'b0;
    @(negedge clk);
    stop = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 2) stop = 1'b0;
      if (resultValid || busy) sawValid = 1'b1;
    end
    checkOutput("stop_idle_ignored", 32'(sawValid), 0);
  endtask

  task automatic resetMidCount();
    bit sawActivity;
    sawActivity = 1'b0;
    @(negedge clk);
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    expMissed = 0;
    stop = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (c == 2) stop = 1'b0;
      if (resultValid || busy) sawActivity = 1'b1;
    end
    checkOutput("rstmid_no_result", 32'(sawActivity), 0);
    checkOutput("rstmid_missed", 32'(missedStarts), 0);
    checkOutput("rstmid_interval", 32'(resultInterval), 0);
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    stop        = 1'b0;
    resultReady = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_valid", 32'(resultValid), 0);
    checkOutput("rst_interval", 32'(resultInterval), 0);
    checkOutput("rst_timeout", 32'(resultTimeout), 0);
    checkOutput("rst_missed", 32'(missedStarts), 0);
    repeat (4) @(negedge clk);

    applyStimulus(10, 0, 1'b0, 0);
    applyStimulus(0, 0, 1'b0, 0);
    applyStimulus(1, 0, 1'b0, 0);
    applyStimulus(TIMEOUT - 1, 0, 1'b0, 0);
    applyStimulus(TIMEOUT, 0, 1'b0, 0);
    applyStimulus(TIMEOUT + 5, 0, 1'b0, 0);
    pulseStopIdle();
    applyStimulus(7, 38, 1'b0, 3);
    applyStimulus(12, 0, 1'b1, 0);

    for (int t = 0; t < 25; t++) begin
      applyStimulus(int'($urandom_range(0, TIMEOUT + 3)), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end

    resetMidCount();
    applyStimulus(5, 0, 1'b0, 300);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
